// File: rtl/read_ptr_blk.sv
// Read-side pointer block for a dual-clock FIFO: binary/Gray read pointers,
// write-pointer synchronizer, empty/almost-empty/occupancy and sticky underflow.
module read_ptr_blk #(
  parameter int p_num_entries         = 8,
  parameter int p_ptr_width           = $clog2(p_num_entries) + 1,
  parameter int p_almost_empty_thresh = 1
) (
  input  logic                   clk,
  input  logic                   async_rst,
  input  logic [p_ptr_width-1:0] g_write_ptr_async,
  input  logic                   r_en,
  input  logic                   clr_err,
  output logic [p_ptr_width-1:0] b_read_ptr,
  output logic [p_ptr_width-1:0] g_read_ptr,
  output logic                   empty,
  output logic                   almost_empty,
  output logic [p_ptr_width-1:0] count,
  output logic                   underflow
);

  localparam logic [p_ptr_width-1:0] thresh_c = p_ptr_width'(p_almost_empty_thresh);

  logic [1:0]             rst_sync_reg;
  logic                   rst_int;
  logic [p_ptr_width-1:0] g_wp_meta_reg;
  logic [p_ptr_width-1:0] g_wp_sync_reg;
  logic [p_ptr_width-1:0] b_wp_sync;
  logic [p_ptr_width-1:0] b_read_ptr_reg;
  logic [p_ptr_width-1:0] b_read_ptr_next;
  logic [p_ptr_width-1:0] g_read_ptr_reg;
  logic [p_ptr_width-1:0] g_read_ptr_next;
  logic                   underflow_reg;
  logic                   underflow_next;
  logic                   rd_fire;

  // Reset asserts immediately, releases two edges after async_rst falls.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) rst_sync_reg <= 2'b11;
    else           rst_sync_reg <= {rst_sync_reg[0], 1'b0};
  end

  assign rst_int = rst_sync_reg[1];

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      g_wp_meta_reg  <= '0;
      g_wp_sync_reg  <= '0;
      b_read_ptr_reg <= '0;
      g_read_ptr_reg <= '0;
      underflow_reg  <= 1'b0;
    end else begin
      g_wp_meta_reg  <= g_write_ptr_async;
      g_wp_sync_reg  <= g_wp_meta_reg;
      b_read_ptr_reg <= b_read_ptr_next;
      g_read_ptr_reg <= g_read_ptr_next;
      underflow_reg  <= underflow_next;
    end
  end

  // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
  assign b_wp_sync[p_ptr_width-1] = g_wp_sync_reg[p_ptr_width-1];
  generate
    for (genvar gi = p_ptr_width - 2; gi >= 0; gi--) begin : g_gray2bin
      assign b_wp_sync[gi] = b_wp_sync[gi+1] ^ g_wp_sync_reg[gi];
    end
  endgenerate

  always_comb begin
    empty           = (g_read_ptr_reg == g_wp_sync_reg);
    rd_fire         = r_en && !empty;
    b_read_ptr_next = b_read_ptr_reg + p_ptr_width'(rd_fire);
    g_read_ptr_next = b_read_ptr_next ^ (b_read_ptr_next >> 1);
    count           = b_wp_sync - b_read_ptr_reg;
    almost_empty    = (count <= thresh_c);
    // A read request while empty wins over a same-cycle clear.
    underflow_next  = underflow_reg;
    if (r_en && empty) underflow_next = 1'b1;
    else if (clr_err)  underflow_next = 1'b0;
  end

  assign b_read_ptr = b_read_ptr_reg;
  assign g_read_ptr = g_read_ptr_reg;
  assign underflow  = underflow_reg;

endmodule

// File: tb/tb_read_ptr_blk.sv
// Directed bench for read_ptr_blk: reset, sync latency, drain, underflow,
// pointer wrap, full occupancy and mid-stream asynchronous reset.
module tb_read_ptr_blk;

  logic       clk = 1'b0;
  logic       async_rst;
  logic [3:0] g_write_ptr_async;
  logic       r_en;
  logic       clr_err;
  logic [3:0] b_read_ptr;
  logic [3:0] g_read_ptr;
  logic       empty;
  logic       almost_empty;
  logic [3:0] count;
  logic       underflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] gray_tbl [16];
  logic [3:0] exp_rp;
  logic [3:0] wb;

  always #5 clk = ~clk;

  read_ptr_blk #(
    .p_num_entries(8),
    .p_ptr_width(4),
    .p_almost_empty_thresh(1)
  ) dut (
    .clk(clk),
    .async_rst(async_rst),
    .g_write_ptr_async(g_write_ptr_async),
    .r_en(r_en),
    .clr_err(clr_err),
    .b_read_ptr(b_read_ptr),
    .g_read_ptr(g_read_ptr),
    .empty(empty),
    .almost_empty(almost_empty),
    .count(count),
    .underflow(underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    gray_tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    async_rst = 1'b1;
    g_write_ptr_async = 4'b0000;
    r_en = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    async_rst = 1'b0;
    check("rst_b_rp", b_read_ptr, 0);
    check("rst_g_rp", g_read_ptr, 0);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_aempty", almost_empty, 1);
    check("rst_underflow", underflow, 0);
    tick; tick;

    // Write pointer at binary 2 takes two edges to become visible.
    g_write_ptr_async = 4'b0011;
    tick;
    check("sync_empty_edge1", empty, 1);
    tick;
    check("sync_empty_edge2", empty, 0);
    check("sync_count", count, 2);
    check("sync_aempty", almost_empty, 0);

    r_en = 1'b1;
    tick;
    check("drain1_b_rp", b_read_ptr, 1);
    check("drain1_count", count, 1);
    check("drain1_aempty", almost_empty, 1);
    tick;
    check("drain2_b_rp", b_read_ptr, 2);
    check("drain2_g_rp", g_read_ptr, 4'b0011);
    check("drain2_empty", empty, 1);
    check("drain2_underflow", underflow, 0);
    tick;
    check("uflow_b_rp", b_read_ptr, 2);
    check("uflow_g_rp", g_read_ptr, 4'b0011);
    check("uflow_set", underflow, 1);

    clr_err = 1'b1;
    tick;
    check("uflow_set_wins", underflow, 1);
    r_en = 1'b0;
    tick;
    check("uflow_cleared", underflow, 0);
    clr_err = 1'b0;

    // Lockstep: one write then one read, 14 times; read pointer wraps 15 -> 0.
    wb = 4'd2;
    exp_rp = 4'd2;
    for (int i = 0; i < 14; i++) begin
      wb = wb + 4'd1;
      g_write_ptr_async = gray_tbl[wb];
      tick; tick;
      check("wrap_count_pre", count, 1);
      r_en = 1'b1;
      tick;
      r_en = 1'b0;
      exp_rp = exp_rp + 4'd1;
      check("wrap_b_rp", b_read_ptr, exp_rp);
      check("wrap_g_rp", g_read_ptr, gray_tbl[exp_rp]);
      check("wrap_empty", empty, 1);
    end
    check("wrap_end_b_rp", b_read_ptr, 0);
    check("wrap_end_g_rp", g_read_ptr, 4'b0000);

    // Write binary 8 against read 0: full, wrap bit differs.
    g_write_ptr_async = 4'b1100;
    tick; tick;
    check("full_count", count, 8);
    check("full_empty", empty, 0);
    check("full_aempty", almost_empty, 0);

    r_en = 1'b1;
    tick; tick; tick;
    check("mid_count5", count, 5);
    check("mid_b_rp", b_read_ptr, 3);
    #2;
    async_rst = 1'b1;
    #1;
    check("mid_rst_b_rp", b_read_ptr, 0);
    check("mid_rst_g_rp", g_read_ptr, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_count", count, 0);
    tick;
    check("mid_rst_hold_b_rp", b_read_ptr, 0);
    check("mid_rst_hold_count", count, 0);
    r_en = 1'b0;
    async_rst = 1'b0;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
